// File: rtl/cmd_dec_seq.sv
// Instruction-to-ALU-enable decoder with registered one-hot outputs and multi-cycle mul/div hold.
// Optional sticky illegal-opcode trap: define CMD_DEC_TRAP_EN to add the trap/trap_clr ports.
module cmd_dec_seq #(
  parameter int OPC_W         = 4,
  parameter int NUM_OPS       = 11,
  parameter int MUL_OPC       = 10,
  parameter int DIV_OPC       = 11,
  parameter int MULDIV_CYCLES = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         instruction,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic               disable_i,
  output logic [NUM_OPS-1:0] op,
  output logic               op_valid,
  output logic               busy
`ifdef CMD_DEC_TRAP_EN
  ,
  output logic               trap,
  input  logic               trap_clr
`endif
);

  localparam int CNT_W = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;
  localparam bit MD_HOLD = (MULDIV_CYCLES > 1);
  localparam logic [OPC_W-1:0] MUL_C = OPC_W'(MUL_OPC);
  localparam logic [OPC_W-1:0] DIV_C = OPC_W'(DIV_OPC);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    MULTI
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_OPS-1:0] op_q, op_d;
  logic               op_valid_q, op_valid_d;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [OPC_W-1:0]   opc;
  logic [NUM_OPS-1:0] onehot;
  logic               legal;
  logic               is_md;
  logic               accept;
  logic               illegal_acc;
  logic               unused_hi;

  assign opc       = instruction[OPC_W-1:0];
  assign unused_hi = ^instruction[7:OPC_W];

  always_comb begin
    onehot = '0;
    for (int unsigned i = 0; i < NUM_OPS; i++) begin
      onehot[i] = (opc == OPC_W'(i + 1));
    end
  end

  assign legal       = (opc != '0) && (32'(opc) <= 32'(NUM_OPS));
  assign is_md       = legal && ((opc == MUL_C) || (opc == DIV_C));
  assign instr_ready = !disable_i && (state_q != MULTI);
  assign accept      = instr_valid && instr_ready;
  assign illegal_acc = accept && !legal;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    op_valid_d = op_valid_q;
    busy_d     = busy_q;
    cnt_d      = cnt_q;

    if (disable_i) begin
      state_d    = IDLE;
      op_d       = '0;
      op_valid_d = 1'b0;
      busy_d     = 1'b0;
      cnt_d      = '0;
    end else begin
      case (state_q)
        MULTI: begin
          if (cnt_q == '0) begin
            state_d    = IDLE;
            op_d       = '0;
            op_valid_d = 1'b0;
            busy_d     = 1'b0;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: begin
          // IDLE and EXEC share the accept path, which gives back-to-back issue from EXEC
          if (accept && legal) begin
            op_d       = onehot;
            op_valid_d = 1'b1;
            if (is_md && MD_HOLD) begin
              state_d = MULTI;
              busy_d  = 1'b1;
              cnt_d   = CNT_W'(MULDIV_CYCLES - 1);
            end else begin
              state_d = EXEC;
              busy_d  = 1'b0;
              cnt_d   = '0;
            end
          end else begin
            state_d    = IDLE;
            op_d       = '0;
            op_valid_d = 1'b0;
            busy_d     = 1'b0;
            cnt_d      = '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      op_q       <= '0;
      op_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      op_valid_q <= op_valid_d;
      busy_q     <= busy_d;
      cnt_q      <= cnt_d;
    end
  end

  assign op       = op_q & {NUM_OPS{!disable_i}};
  assign op_valid = op_valid_q & !disable_i;
  assign busy     = busy_q;

`ifdef CMD_DEC_TRAP_EN
  logic trap_q, trap_d;

  always_comb begin
    trap_d = trap_q;
    if (illegal_acc) begin
      trap_d = 1'b1;
    end else if (trap_clr) begin
      trap_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trap_q <= 1'b0;
    end else begin
      trap_q <= trap_d;
    end
  end

  assign trap = trap_q;
`else
  logic unused_trap;
  assign unused_trap = illegal_acc;
`endif

endmodule

// File: tb/tb_cmd_dec_seq.sv
// Randomized scoreboard bench for cmd_dec_seq against a hold-count reference model.
module tb_cmd_dec_seq;

  localparam int NUM_OPS = 11;
  localparam int MULC    = 10;
  localparam int DIVC    = 11;
  localparam int CYC     = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic [7:0]         instruction;
  logic               instr_valid;
  logic               instr_ready;
  logic               dis;
  logic [NUM_OPS-1:0] op;
  logic               op_valid;
  logic               busy;
  logic               trap;
  logic               trap_clr;

  cmd_dec_seq #(
    .OPC_W(4), .NUM_OPS(NUM_OPS), .MUL_OPC(MULC), .DIV_OPC(DIVC), .MULDIV_CYCLES(CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .instruction(instruction),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .disable_i(dis),
    .op(op),
    .op_valid(op_valid),
    .busy(busy)
`ifdef CMD_DEC_TRAP_EN
    ,
    .trap(trap),
    .trap_clr(trap_clr)
`endif
  );

`ifndef CMD_DEC_TRAP_EN
  assign trap = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NUM_OPS-1:0] op;
    logic               vld;
    logic               busy;
    logic               rdy;
    logic               trap;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   checking = 0;

  // Reference model: the op currently presented and how many display cycles remain for mul/div
  int m_opc  = 0;
  int m_left = 0;
  bit m_md   = 0;
  bit m_trap = 0;

  function automatic exp_t model_out(input bit d);
    exp_t e;
    e.op   = (m_opc != 0 && !d) ? NUM_OPS'(1 << (m_opc - 1)) : '0;
    e.vld  = (m_opc != 0 && !d);
    e.busy = m_md;
    e.rdy  = !d && !m_md;
    e.trap = m_trap;
    return e;
  endfunction

  task automatic model_step(input bit d, input bit v, input logic [7:0] ins, input bit c);
    int o;
    bit illegal;
    o = int'(ins) % 16;
    illegal = 0;
    if (d) begin
      m_opc = 0; m_md = 0; m_left = 0;
    end else if (m_md) begin
      m_left--;
      if (m_left == 0) begin
        m_opc = 0; m_md = 0;
      end
    end else if (v) begin
      if (o >= 1 && o <= NUM_OPS) begin
        m_opc = o;
        if ((o == MULC || o == DIVC) && CYC > 1) begin
          m_md = 1; m_left = CYC;
        end
      end else begin
        m_opc = 0;
        illegal = 1;
      end
    end else begin
      m_opc = 0;
    end
`ifdef CMD_DEC_TRAP_EN
    if (illegal) m_trap = 1;
    else if (c) m_trap = 0;
`endif
  endtask

  // Caller is positioned just after a rising edge; returns just after the next one
  task automatic drive(input bit d, input bit v, input logic [7:0] ins, input bit c);
    dis = d; instr_valid = v; instruction = ins; trap_clr = c;
    exp_q.push_back(model_out(d));
    @(posedge clk);
    model_step(d, v, ins, c);
    #1;
  endtask

  always @(negedge clk) begin
    if (checking) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow: got op=%h with no expected entry", op);
      end else begin
        exp_t e;
        exp_t a;
        e = exp_q.pop_front();
        a = '{op: op, vld: op_valid, busy: busy, rdy: instr_ready, trap: trap};
        if (a !== e) begin
          errors++;
          $display("FAIL cycle_out @%0t: got op=%h vld=%b busy=%b rdy=%b trap=%b, want op=%h vld=%b busy=%b rdy=%b trap=%b",
                   $time, a.op, a.vld, a.busy, a.rdy, a.trap, e.op, e.vld, e.busy, e.rdy, e.trap);
        end
      end
    end
  end

  task automatic direct_check(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  initial begin
    rst = 1'b0; dis = 1'b0; instr_valid = 1'b0; instruction = '0; trap_clr = 1'b0;
    #12;
    direct_check("reset_op", 16'(op), 16'h0);
    direct_check("reset_flags", {12'h0, op_valid, busy, instr_ready, trap}, 16'h0002);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checking = 1;

    // add, then idle
    drive(0, 1, 8'h01, 0);
    drive(0, 0, 8'h00, 0);
    drive(0, 0, 8'h00, 0);
    // back-to-back with ignored upper nibble
    drive(0, 1, 8'h02, 0);
    drive(0, 1, 8'h08, 0);
    drive(0, 1, 8'h09, 0);
    drive(0, 1, 8'hF2, 0);
    drive(0, 0, 8'h00, 0);
    // multiply hold with the next instruction waiting
    drive(0, 1, 8'h0A, 0);
    for (int i = 0; i < CYC + 1; i++) drive(0, 1, 8'h01, 0);
    drive(0, 0, 8'h00, 0);
    // divide aborted by disable, instruction offered under disable
    drive(0, 1, 8'h0B, 0);
    drive(0, 0, 8'h00, 0);
    drive(1, 1, 8'h03, 0);
    drive(1, 1, 8'h03, 0);
    drive(0, 0, 8'h00, 0);
    drive(0, 0, 8'h00, 0);
    // illegal opcodes and trap behaviour
    drive(0, 1, 8'h00, 0);
    drive(0, 1, 8'h0C, 0);
    drive(0, 0, 8'h00, 1);
    drive(0, 0, 8'h00, 0);
    drive(0, 1, 8'h0F, 1);
    drive(1, 0, 8'h00, 0);
    drive(0, 0, 8'h00, 1);
    drive(0, 0, 8'h00, 0);

    for (int n = 0; n < 1500; n++) begin
      bit d, v, c;
      logic [7:0] ins;
      d   = ($urandom_range(0, 99) < 8);
      v   = ($urandom_range(0, 99) < 70);
      c   = ($urandom_range(0, 99) < 15);
      ins = 8'($urandom);
      if ($urandom_range(0, 3) == 0) ins[3:0] = ($urandom_range(0, 1) != 0) ? 4'hA : 4'hB;
      drive(d, v, ins, c);
    end
    drive(0, 0, 8'h00, 0);

    // async reset while a multiply is mid-hold
    drive(0, 1, 8'h0A, 0);
    drive(0, 0, 8'h00, 0);
    drive(0, 0, 8'h00, 0);
    drive(0, 0, 8'h00, 0);
    checking = 0;
    direct_check("pre_reset_busy", {15'h0, busy}, 16'h0001);
    #2 rst = 1'b0;
    #1;
    direct_check("async_reset_op", 16'(op), 16'h0);
    direct_check("async_reset_flags", {13'h0, op_valid, busy, trap}, 16'h0);
    @(posedge clk); #1;
    rst = 1'b1;

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: got %0d entries want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
